// File: rtl/alu_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 op encoding,
// FSM states and the mode select for the per-iteration datapath.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  typedef enum logic {
    M_MUL,
    M_DIV
  } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One CALC iteration retiring STEP bits: right-shifting shift-add for multiply,
// left-shifting restoring trial-subtract for divide.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int STEP = 1
) (
  input  step_mode_e         mode,
  input  logic [2*XLEN:0]    acc_in,
  input  logic [XLEN-1:0]    operand,
  output logic [2*XLEN:0]    acc_out
);

  // Multiply layout: {0, hi product, multiplier}. Divide layout: {remainder(XLEN+1), dividend/quotient}.
  logic [2*XLEN:0] a;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shr;
  logic [XLEN+1:0] diff;

  always_comb begin
    a    = acc_in;
    sum  = '0;
    shr  = '0;
    diff = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mode == M_MUL) begin
        sum = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        a   = {1'b0, sum, a[XLEN-1:1]};
      end else begin
        // Remainder stays below the divisor, so its MSB is always zero here.
        shr  = {a[2*XLEN-1:XLEN], a[XLEN-1]};
        diff = {1'b0, shr} - {2'b00, operand};
        if (!diff[XLEN+1]) a = {diff[XLEN:0], a[XLEN-2:0], 1'b1};
        else               a = {shr, a[XLEN-2:0], 1'b0};
      end
    end
    acc_out = a;
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit with ok/valid handshake,
// result hold under back-pressure and flush.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            ok_o,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_i,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o,
  input  logic            ok_i,
  output logic            busy,
  input  logic            flush
);

  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state, state_d;
  muldiv_op_e      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] a_q, b_q, bmag;
  logic [2*XLEN:0] acc, acc_nxt;
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            accept;

  assign ok_o         = (state == S_IDLE) && !flush;
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign accept       = in_valid && ok_o;

  // PREP: magnitudes, signs, special cases
  logic            sgn_a_en, sgn_b_en, sa, sb, div_zero, ovf, special, neg_c;
  logic [XLEN-1:0] amag, bmag_c, special_res;

  always_comb begin
    sgn_a_en    = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    sgn_b_en    = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    sa          = sgn_a_en && a_q[XLEN-1];
    sb          = sgn_b_en && b_q[XLEN-1];
    amag        = sa ? -a_q : a_q;
    bmag_c      = sb ? -b_q : b_q;
    div_zero    = op_q[2] && (b_q == '0);
    ovf         = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MOST_NEG) && (&b_q);
    special     = div_zero || ovf;
    // op[1] selects remainder within the divide group
    if (div_zero) special_res = op_q[1] ? a_q : '1;
    else          special_res = op_q[1] ? '0 : a_q;
    neg_c       = (op_q[2] && op_q[1]) ? sa : (sa ^ sb);
  end

  muldiv_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .mode    (op_q[2] ? M_DIV : M_MUL),
    .acc_in  (acc),
    .operand (bmag),
    .acc_out (acc_nxt)
  );

  // FIX: sign correction and output select
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;
  logic              unused_acc_msb;

  assign unused_acc_msb = acc[2*XLEN];

  always_comb begin
    prod_s = neg_q ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
    quo_s  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_s;
      default:                      fix_res = rem_s;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) state_d = S_PREP;
      S_PREP: state_d = special ? S_DONE : S_CALC;
      S_CALC: if (cnt == CW'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (ok_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_MUL;
      rd_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      bmag   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      result <= '0;
      rd_o   <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: if (accept) begin
          op_q <= muldiv_op_e'(op);
          rd_q <= rd_i;
          a_q  <= rs1;
          b_q  <= rs2;
        end
        S_PREP: begin
          // Same initial layout serves both modes: zero upper half, |A| below.
          acc   <= {{(XLEN+1){1'b0}}, amag};
          bmag  <= bmag_c;
          neg_q <= neg_c;
          cnt   <= CW'(N);
          if (special) begin
            result <= special_res;
            rd_o   <= rd_q;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          result <= fix_res;
          rd_o   <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule
